// File: rtl/branch_target_table_pkg.sv
// Shared definitions for the branch target table: default widths and the
// clear-sweep FSM state type.
package branch_target_table_pkg;

    localparam int BTT_D = 10;
    localparam int BTT_A = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } btt_state_e;

endpackage

// File: rtl/branch_target_table_if.sv
// Lookup, programming and clear signals of the branch target table, bundled
// so the table and its user agree on one port list.
interface branch_target_table_if
    import branch_target_table_pkg::*;
#(
    parameter int D = BTT_D,
    parameter int A = BTT_A
) ();

    logic         rd_en;
    logic [A-1:0] rd_addr;
    logic [D-1:0] pc;
    logic         rd_valid;
    logic [D-1:0] target;
    logic         hit;
    logic         wr_en;
    logic [A-1:0] wr_addr;
    logic [D-1:0] wr_data;
    logic         wr_rel;
    logic         clr;
    logic         busy;

    modport master (
        output rd_en, rd_addr, pc, wr_en, wr_addr, wr_data, wr_rel, clr,
        input  rd_valid, target, hit, busy
    );

    modport slave (
        input  rd_en, rd_addr, pc, wr_en, wr_addr, wr_data, wr_rel, clr,
        output rd_valid, target, hit, busy
    );

endinterface

// File: rtl/branch_target_table_target_calc.sv
// Resolves one table entry against the current PC: absolute, PC-relative or
// fall-through when the entry is not valid.
module btt_target_calc
    import branch_target_table_pkg::*;
#(
    parameter int D = BTT_D
) (
    input  logic         i_valid,
    input  logic         i_rel,
    input  logic [D-1:0] i_data,
    input  logic [D-1:0] i_pc,
    output logic [D-1:0] o_target,
    output logic         o_hit
);

    // Adding at width D gives the two's-complement offset its sign for free
    // and makes wrap-around silent.
    always_comb begin
        o_hit    = i_valid;
        o_target = i_pc + D'(1);
        if (i_valid) begin
            o_target = i_rel ? (i_pc + i_data) : i_data;
        end
    end

endmodule

// File: rtl/branch_target_table.sv
// Branch target table: one-cycle lookups with write-first forwarding and a
// one-entry-per-cycle clear sweep that blocks programming while it runs.
module branch_target_table
    import branch_target_table_pkg::*;
#(
    parameter int D = BTT_D,
    parameter int A = BTT_A
) (
    input logic                 clk,
    input logic                 reset,
    branch_target_table_if.slave bus
);

    localparam int DEPTH = 2**A;

    btt_state_e   r_state;
    btt_state_e   w_state_next;
    logic [A-1:0] r_count;
    logic [A-1:0] w_count_next;

    logic [DEPTH-1:0] r_valid;
    logic [DEPTH-1:0] r_rel;
    logic [D-1:0]     r_data [DEPTH];

    logic         r_rd_valid;
    logic         r_hit;
    logic [D-1:0] r_target;

    logic         w_wr_accept;
    logic         w_fwd;
    logic         w_ent_valid;
    logic         w_ent_rel;
    logic [D-1:0] w_ent_data;
    logic [D-1:0] w_calc_target;
    logic         w_calc_hit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_count <= '0;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
        end
    end

    // The sweep ends on the last entry rather than wrapping the counter.
    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        case (r_state)
            IDLE: begin
                if (bus.clr) begin
                    w_state_next = CLEAR;
                    w_count_next = '0;
                end
            end
            CLEAR: begin
                if (r_count == A'(DEPTH - 1)) begin
                    w_state_next = IDLE;
                    w_count_next = '0;
                end else begin
                    w_count_next = r_count + A'(1);
                end
            end
            default: begin
                w_state_next = IDLE;
                w_count_next = '0;
            end
        endcase
    end

    assign w_wr_accept = (r_state == IDLE) && bus.wr_en && !bus.clr;
    assign w_fwd       = w_wr_accept && (bus.wr_addr == bus.rd_addr);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= '0;
        end else if (r_state == CLEAR) begin
            r_valid[r_count] <= 1'b0;
        end else if (w_wr_accept) begin
            r_valid[bus.wr_addr] <= 1'b1;
        end
    end

    // Payload is never exposed while its valid bit is low, so it needs no reset.
    always_ff @(posedge clk) begin
        if (r_state == CLEAR) begin
            r_data[r_count] <= '0;
            r_rel[r_count]  <= 1'b0;
        end else if (w_wr_accept) begin
            r_data[bus.wr_addr] <= bus.wr_data;
            r_rel[bus.wr_addr]  <= bus.wr_rel;
        end
    end

    always_comb begin
        w_ent_valid = r_valid[bus.rd_addr];
        w_ent_rel   = r_rel[bus.rd_addr];
        w_ent_data  = r_data[bus.rd_addr];
        if (w_fwd) begin
            w_ent_valid = 1'b1;
            w_ent_rel   = bus.wr_rel;
            w_ent_data  = bus.wr_data;
        end
        if (r_state == CLEAR) begin
            w_ent_valid = 1'b0;
        end
    end

    btt_target_calc #(.D(D)) u_calc (
        .i_valid  (w_ent_valid),
        .i_rel    (w_ent_rel),
        .i_data   (w_ent_data),
        .i_pc     (bus.pc),
        .o_target (w_calc_target),
        .o_hit    (w_calc_hit)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_valid <= 1'b0;
            r_hit      <= 1'b0;
            r_target   <= '0;
        end else begin
            r_rd_valid <= bus.rd_en;
            if (bus.rd_en) begin
                r_hit    <= w_calc_hit;
                r_target <= w_calc_target;
            end
        end
    end

    assign bus.rd_valid = r_rd_valid;
    assign bus.hit      = r_hit;
    assign bus.target   = r_target;
    assign bus.busy     = (r_state == CLEAR);

endmodule

// File: tb/tb_branch_target_table.sv
// Self-checking bench for branch_target_table: directed vector table, clear and
// reset corner sequences, then random traffic against a behavioural model.
module tb_branch_target_table;
    import branch_target_table_pkg::*;

    localparam int D     = BTT_D;
    localparam int A     = BTT_A;
    localparam int DEPTH = 2**A;
    localparam int MOD   = 2**D;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    branch_target_table_if bus ();

    branch_target_table dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        int rdEn;  int rdAddr; int pc;
        int wrEn;  int wrAddr; int wrData; int wrRel; int clr;
        int expValid; int expHit; int expTarget; int expBusy;
    } vec_t;

    int testsRun    = 0;
    int testsFailed = 0;

    int mData  [DEPTH];
    bit mRel   [DEPTH];
    bit mValid [DEPTH];
    int clearLeft;
    bit expValid, expHit, expBusy;
    int expTarget;

    function automatic int wrapD(int x);
        return ((x % MOD) + MOD) % MOD;
    endfunction

    function automatic int signedOf(int x);
        return (x >= MOD / 2) ? x - MOD : x;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < DEPTH; i++) mValid[i] = 1'b0;
        clearLeft = 0;
        expValid  = 1'b0;
        expHit    = 1'b0;
        expTarget = 0;
        expBusy   = 1'b0;
    endtask

    // Predicts the outputs after the coming edge from the inputs now on the bus.
    task automatic modelStep();
        int ra, wa, pc, data;
        bit busyNow, wrOk, rel, valid;
        ra      = int'(bus.rd_addr);
        wa      = int'(bus.wr_addr);
        pc      = int'(bus.pc);
        busyNow = clearLeft > 0;
        wrOk    = !busyNow && bus.wr_en && !bus.clr;
        valid   = mValid[ra];
        rel     = mRel[ra];
        data    = mData[ra];
        if (wrOk && wa == ra) begin
            valid = 1'b1;
            rel   = bus.wr_rel;
            data  = int'(bus.wr_data);
        end
        expValid = bus.rd_en;
        if (bus.rd_en) begin
            if (busyNow || !valid) begin
                expHit    = 1'b0;
                expTarget = wrapD(pc + 1);
            end else begin
                expHit    = 1'b1;
                expTarget = rel ? wrapD(pc + signedOf(data)) : data;
            end
        end
        if (busyNow) begin
            mValid[DEPTH - clearLeft] = 1'b0;
            mData[DEPTH - clearLeft]  = 0;
            mRel[DEPTH - clearLeft]   = 1'b0;
            clearLeft--;
        end else if (bus.clr) begin
            clearLeft = DEPTH;
        end else if (bus.wr_en) begin
            mValid[wa] = 1'b1;
            mRel[wa]   = bus.wr_rel;
            mData[wa]  = int'(bus.wr_data);
        end
        expBusy = clearLeft > 0;
    endtask

    task automatic applyStimulus(input int rdEn, input int rdAddr, input int pc,
                                 input int wrEn, input int wrAddr, input int wrData,
                                 input int wrRel, input int clr);
        bus.rd_en   = rdEn[0];
        bus.rd_addr = A'(rdAddr);
        bus.pc      = D'(pc);
        bus.wr_en   = wrEn[0];
        bus.wr_addr = A'(wrAddr);
        bus.wr_data = D'(wrData);
        bus.wr_rel  = wrRel[0];
        bus.clr     = clr[0];
        modelStep();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic checkModel(input string name);
        checkOutput({name, " rd_valid"}, 32'(bus.rd_valid), 32'(expValid));
        checkOutput({name, " busy"}, 32'(bus.busy), 32'(expBusy));
        if (expValid) begin
            checkOutput({name, " hit"}, 32'(bus.hit), 32'(expHit));
            checkOutput({name, " target"}, 32'(bus.target), 32'(expTarget));
        end
    endtask

    task automatic checkResetValues(input string name);
        checkOutput({name, " busy"}, 32'(bus.busy), 32'd0);
        checkOutput({name, " rd_valid"}, 32'(bus.rd_valid), 32'd0);
        checkOutput({name, " hit"}, 32'(bus.hit), 32'd0);
        checkOutput({name, " target"}, 32'(bus.target), 32'd0);
    endtask

    vec_t vecs[12];
    int   busyCycles;

    initial begin
        vecs = '{
            '{1, 3, 100,  0, 0, 0,    0, 0,  1, 0, 101,  0},
            '{0, 0, 0,    1, 2, 80,   0, 0,  0, 0, 0,    0},
            '{1, 2, 7,    0, 0, 0,    0, 0,  1, 1, 80,   0},
            '{1, 5, 0,    1, 5, 58,   0, 0,  1, 1, 58,   0},
            '{0, 0, 0,    1, 4, 1019, 1, 0,  0, 0, 0,    0},
            '{1, 4, 4,    0, 0, 0,    0, 0,  1, 1, 1023, 0},
            '{0, 0, 0,    1, 6, 20,   1, 0,  0, 0, 0,    0},
            '{1, 6, 1020, 0, 0, 0,    0, 0,  1, 1, 16,   0},
            '{1, 9, 1023, 0, 0, 0,    0, 0,  1, 0, 0,    0},
            '{1, 7, 5,    1, 7, 300,  0, 0,  1, 1, 300,  0},
            '{0, 2, 5,    0, 0, 0,    0, 0,  0, 0, 0,    0},
            '{1, 5, 900,  0, 0, 0,    0, 0,  1, 1, 58,   0}
        };

        bus.rd_en = 1'b0; bus.rd_addr = '0; bus.pc = '0;
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.wr_rel = 1'b0; bus.clr = 1'b0;

        #1 reset = 1'b1;
        modelReset();
        #2;
        checkResetValues("reset");
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rdEn, vecs[i].rdAddr, vecs[i].pc, vecs[i].wrEn,
                          vecs[i].wrAddr, vecs[i].wrData, vecs[i].wrRel, vecs[i].clr);
            checkOutput($sformatf("vec%0d rd_valid", i), 32'(bus.rd_valid), 32'(vecs[i].expValid));
            checkOutput($sformatf("vec%0d busy", i), 32'(bus.busy), 32'(vecs[i].expBusy));
            if (vecs[i].expValid != 0) begin
                checkOutput($sformatf("vec%0d hit", i), 32'(bus.hit), 32'(vecs[i].expHit));
                checkOutput($sformatf("vec%0d target", i), 32'(bus.target), 32'(vecs[i].expTarget));
            end
        end

        // Full table programmed, then clr collides with a write to entry 0.
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(0, 0, 0, 1, i, i * 3 + 1, 0, 0);
            checkModel("program");
        end
        applyStimulus(1, 0, 50, 1, 0, 999, 0, 1);
        checkModel("clr start");
        checkOutput("clr start target", 32'(bus.target), 32'd1);
        busyCycles = 0;
        for (int k = 0; k < 40 && bus.busy; k++) begin
            busyCycles++;
            applyStimulus(1, k % DEPTH, k * 7, 1, 3, 55, 0, (k == 4) ? 1 : 0);
            checkModel("sweep");
        end
        checkOutput("busy cycle count", 32'(busyCycles), 32'(DEPTH));
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1, i, 200 + i, 0, 0, 0, 0, 0);
            checkModel("post clear");
            checkOutput("post clear hit", 32'(bus.hit), 32'd0);
        end

        // Reset lands in the middle of a sweep.
        applyStimulus(0, 0, 0, 1, 5, 123, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
        for (int k = 0; k < 7; k++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
            checkModel("sweep before reset");
        end
        #2 reset = 1'b1;
        modelReset();
        #1;
        checkResetValues("mid-sweep reset");
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(0, 0, 0, 1, 3, 77, 0, 0);
        checkModel("write after reset");
        applyStimulus(1, 3, 10, 0, 0, 0, 0, 0);
        checkModel("read after reset");
        checkOutput("read after reset target", 32'(bus.target), 32'd77);
        applyStimulus(1, 5, 10, 0, 0, 0, 0, 0);
        checkModel("invalidated by reset");

        for (int n = 0; n < 400; n++) begin
            applyStimulus(int'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH - 1)),
                          int'($urandom_range(0, MOD - 1)), int'($urandom_range(0, 1)),
                          int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, MOD - 1)),
                          int'($urandom_range(0, 1)), ($urandom_range(0, 39) == 0) ? 1 : 0);
            checkModel("random");
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/branch_target_table.md
BRANCH_TARGET_TABLE -- requirements
Module: branch_target_table

Interface
REQ-001 Parameter D, default 10: target/PC width in bits.
REQ-002 Parameter A, default 4: entry-address width; DEPTH = 2**A entries.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 rd_en  input  1  lookup request.
REQ-006 rd_addr  input  A  entry to look up.
REQ-007 pc  input  D  current PC, sampled with rd_en; base for relative entries.
REQ-008 rd_valid  output  1  lookup result valid, one cycle after rd_en.
REQ-009 target  output  D  resolved branch target.
REQ-010 hit  output  1  looked-up entry was valid.
REQ-011 wr_en  input  1  program one entry.
REQ-012 wr_addr  input  A  entry to program.
REQ-013 wr_data  input  D  absolute target, or two's-complement offset when wr_rel=1.
REQ-014 wr_rel  input  1  entry mode: 0 absolute, 1 PC-relative.
REQ-015 clr  input  1  start a full-table clear sweep.
REQ-016 busy  output  1  clear sweep in progress.

Function
REQ-017 Each entry SHALL hold data[D], rel[1], valid[1].
REQ-018 Lookup latency SHALL be exactly 1 cycle: rd_en at edge N gives rd_valid=1 with target/hit after edge N; rd_valid=0 when rd_en was 0.
REQ-019 Valid absolute entry: target = data, hit=1.
REQ-020 Valid relative entry: target = (pc + data) mod 2**D, data sign-extended; no overflow flag; wrap is silent.
REQ-021 Invalid entry: target = (pc + 1) mod 2**D (fall-through), hit=0.
REQ-022 Write while IDLE: data, rel and valid=1 SHALL be updated at the edge.
REQ-023 Same-cycle read and write to the same address SHALL be write-first: the lookup returns the new entry.
REQ-024 FSM states IDLE, CLEAR; IDLE->CLEAR on clr=1; CLEAR->IDLE after the entry DEPTH-1 is cleared.
REQ-025 CLEAR SHALL zero one entry per cycle (data=0, rel=0, valid=0) from address 0 upward; the sweep takes DEPTH cycles; busy=1 throughout.
REQ-026 clr and wr_en in the same IDLE cycle: clr wins, write dropped.
REQ-027 During CLEAR: wr_en and clr SHALL be ignored; lookups complete with rd_valid=1, hit=0, target=pc+1.
REQ-028 Sweep counter width A; terminal at DEPTH-1 with no wrap to 0 inside the sweep.

Reset
REQ-029 reset SHALL force state IDLE, busy=0, rd_valid=0, hit=0, target=0, sweep counter 0, all valid bits 0, asynchronously.
REQ-030 data/rel storage need not be reset; an invalid entry never exposes its data.
REQ-031 reset mid-sweep SHALL abort to IDLE; no partial-clear state survives.

Structure
REQ-032 A shared package SHALL hold the FSM state enum (IDLE, CLEAR) and the default D/A constants.
REQ-033 One sub-module, btt_target_calc (combinational: entry, pc -> target, hit), SHALL implement REQ-019..021.

Verification
REQ-034 After reset, lookup addr 3 pc=100 -> next cycle rd_valid=1, hit=0, target=101.
REQ-035 Write addr 2 abs 80, then lookup addr 2 -> target=80, hit=1; write and read addr 5=58 same cycle -> target=58, hit=1.
REQ-036 Write addr 4 rel data=-5 (all ones except bit 2), lookup pc=4 -> target=1023 (D=10); rel +20 at pc=1020 -> target=16.
REQ-037 Program all 16, pulse clr with wr_en to addr 0 -> busy=1 exactly 16 cycles, write dropped, all lookups afterwards hit=0.
REQ-038 Assert reset at sweep cycle 7 -> busy=0 immediately, IDLE, later writes accepted normally.
REQ-039 pc=1023 lookup of invalid entry -> target=0 (wrap), hit=0.
